nec_ir_frame_decoder: RTL

Parametrised NEC infrared frame decoder for the user project area. It samples the demodulated IR receiver line, times marks and spaces with a programmable prescaler, and decodes standard NEC, extended NEC (16-bit address) and NEC repeat codes. Decoded frames are buffered in a FIFO read through a valid/ready port, so firmware polling the Wishbone side can fall several frames behind without loss.

---
 rtl/nec_ir_frame_decoder.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/nec_ir_frame_decoder.sv
// NEC IR frame decoder: times marks/spaces, decodes std/ext/repeat frames
// and queues them in a small FIFO read through a valid/ready port.
module nec_ir_frame_decoder #(
  parameter int TICK_CYCLES = 5625,
  parameter int FIFO_DEPTH  = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        ir_in,
  input  logic                        mode_ext,
  input  logic                        frame_ready,
  input  logic                        clr_ovf,
  output logic                        frame_valid,
  output logic [15:0]                 frame_addr,
  output logic [7:0]                  frame_cmd,
  output logic                        frame_repeat,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        err_pulse,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [6:0] DMAX = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_REP_MARK
  } state_e;

  function automatic logic in_win(
    input logic [6:0] d,
    input logic [6:0] lo,
    input logic [6:0] hi
  );
    return (d >= lo) && (d <= hi);
  endfunction

  logic          sync1_q, sync2_q, mark_q;
  logic          mark, ir_edge, tick;
  logic [PW-1:0] presc_q;
  logic [6:0]    dur_q;

  state_e        state_q, state_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          mode_q, mode_d;
  logic [15:0]   last_addr_q, last_addr_d;
  logic [7:0]    last_cmd_q, last_cmd_d;
  logic          have_last_q, have_last_d;
  logic          err_q, err_d;
  logic          push_q, push_d;
  logic [24:0]   pdata_q, pdata_d;

  logic [7:0]    b0, b1, b2, b3;
  logic          chk_ok;
  logic [15:0]   dec_addr;
  logic          w_lmark, w_ldata, w_lrep, w_mark, w_zero, w_one;

  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          full, pop, wr_en;
  logic [24:0]   head;

  assign mark    = sync2_q ^ ACTIVE_LOW;
  assign ir_edge = mark ^ mark_q;
  assign tick    = (presc_q == PMAX);

  assign w_lmark = in_win(dur_q, 7'd56, 7'd72);
  assign w_ldata = in_win(dur_q, 7'd28, 7'd36);
  assign w_lrep  = in_win(dur_q, 7'd14, 7'd20);
  assign w_mark  = in_win(dur_q, 7'd2, 7'd6);
  assign w_zero  = in_win(dur_q, 7'd2, 7'd6);
  assign w_one   = in_win(dur_q, 7'd10, 7'd14);

  assign b0 = shreg_q[7:0];
  assign b1 = shreg_q[15:8];
  assign b2 = shreg_q[23:16];
  assign b3 = shreg_q[31:24];
  assign chk_ok = (b2 == ~b3) && (mode_q || (b0 == ~b1));
  assign dec_addr = mode_q ? {b1, b0} : {8'h00, b0};

  // Synchronise the pad and remember the previous mark level
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      mark_q  <= 1'b0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      mark_q  <= mark;
    end
  end

  // Sub-tick prescaler and saturating duration counter, both restart on edges
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else if (ir_edge) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick && dur_q != DMAX) dur_q <= dur_q + 7'd1;
    end
  end

  // FSM and decode state registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      mode_q      <= 1'b0;
      last_addr_q <= '0;
      last_cmd_q  <= '0;
      have_last_q <= 1'b0;
      err_q       <= 1'b0;
      push_q      <= 1'b0;
      pdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      mode_q      <= mode_d;
      last_addr_q <= last_addr_d;
      last_cmd_q  <= last_cmd_d;
      have_last_q <= have_last_d;
      err_q       <= err_d;
      push_q      <= push_d;
      pdata_q     <= pdata_d;
    end
  end

  // Next-state: each state acts only on an edge; a long silence aborts
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    mode_d      = mode_q;
    last_addr_d = last_addr_q;
    last_cmd_d  = last_cmd_q;
    have_last_d = have_last_q;
    err_d       = 1'b0;
    push_d      = 1'b0;
    pdata_d     = pdata_q;
    if (state_q != S_IDLE && !ir_edge && dur_q == DMAX) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else if (ir_edge) begin
      unique case (state_q)
        S_IDLE: begin
          if (mark) state_d = S_LEAD_MARK;
        end
        S_LEAD_MARK: begin
          if (w_lmark) begin
            state_d = S_LEAD_SPACE;
            mode_d  = mode_ext;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_LEAD_SPACE: begin
          if (w_ldata) begin
            state_d  = S_BIT_MARK;
            bitcnt_d = '0;
          end else if (w_lrep) begin
            state_d = S_REP_MARK;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BIT_MARK: begin
          if (w_mark) begin
            state_d = S_BIT_SPACE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BIT_SPACE: begin
          if (w_zero || w_one) begin
            shreg_d  = {w_one, shreg_q[31:1]};
            bitcnt_d = bitcnt_q + 6'd1;
            state_d  = (bitcnt_d == 6'd32) ? S_STOP_MARK : S_BIT_MARK;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_STOP_MARK: begin
          state_d = S_IDLE;
          if (w_mark && chk_ok) begin
            push_d      = 1'b1;
            pdata_d     = {dec_addr, b2, 1'b0};
            last_addr_d = dec_addr;
            last_cmd_d  = b2;
            have_last_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        S_REP_MARK: begin
          state_d = S_IDLE;
          if (w_mark && have_last_q) begin
            push_d  = 1'b1;
            pdata_d = {last_addr_q, last_cmd_q, 1'b1};
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign full  = (cnt_q == FULL_LVL);
  assign pop   = (cnt_q != '0) && frame_ready;
  assign wr_en = push_q && (!full || pop);

  // FIFO storage; contents need no reset since the head is gated by valid
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= pdata_q;
  end

  // FIFO pointers, level and sticky overflow (set beats clear)
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop) cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
      if (push_q && full && !pop) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign frame_valid  = (cnt_q != '0);
  assign frame_addr   = frame_valid ? head[24:9] : '0;
  assign frame_cmd    = frame_valid ? head[8:1] : '0;
  assign frame_repeat = frame_valid ? head[0] : 1'b0;
  assign fifo_level   = cnt_q;
  assign overflow     = ovf_q;
  assign err_pulse    = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule
